// File: rtl/fir_pkg.sv
// fir_pkg: width derivations shared by the symmetric FIR datapath
// clog2  : bits needed to index v entries
// ncoef  : stored (unique) coefficients of a symmetric odd-length filter
// acc_w  : accumulator width that cannot overflow for full-scale inputs
package fir_pkg;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ncoef(input int ntaps);
        return (ntaps + 1) / 2;
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
        return data_w + 1 + coef_w + clog2(ncoef(ntaps));
    endfunction
endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: round-half-up right shift of the accumulator, then clip to DATA_W
// i_acc  : signed accumulator
// o_data : rounded, saturated sample
// o_sat  : high when clipping occurred
module fir_round_sat #(
    parameter int ACC_W  = 21,
    parameter int DATA_W = 8,
    parameter int SHIFT  = 10
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic        [DATA_W-1:0] o_data,
    output logic                     o_sat
);
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

    // one extra bit so adding the half-LSB can never wrap
    logic signed [ACC_W:0] w_rnd;
    logic                  w_hi;
    logic                  w_lo;

    generate
        if (SHIFT == 0) begin : g_noshift
            assign w_rnd = $signed({i_acc[ACC_W-1], i_acc});
        end else begin : g_shift
            localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
            assign w_rnd = ($signed({i_acc[ACC_W-1], i_acc}) + HALF) >>> SHIFT;
        end
    endgenerate

    assign w_hi   = w_rnd > MAXV;
    assign w_lo   = w_rnd < MINV;
    assign o_sat  = w_hi | w_lo;
    assign o_data = w_hi ? MAXV[DATA_W-1:0] : w_lo ? MINV[DATA_W-1:0] : w_rnd[DATA_W-1:0];
endmodule

// File: rtl/fir_sym_pipe.sv
// fir_sym_pipe: 3-stage symmetric FIR (pre-add, multiply, sum+round+saturate)
// in_valid/in_data/in_ready    : sample input handshake
// out_valid/out_data/out_sat   : result, held until out_ready
// bypass                       : per-sample pass of the group-delayed raw sample
// coef_we/coef_addr/coef_wdata : write of h[0..NCOEF-1]
module fir_sym_pipe
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int NTAPS  = 19,
    parameter int SHIFT  = 10
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_sat,
    input  logic                             out_ready,
    input  logic                             bypass,
    input  logic                             coef_we,
    input  logic [clog2(ncoef(NTAPS))-1:0]   coef_addr,
    input  logic [COEF_W-1:0]                coef_wdata
);
    localparam int NCOEF = ncoef(NTAPS);
    localparam int AW    = clog2(NCOEF);
    localparam int ACC_W = acc_w(DATA_W, COEF_W, NTAPS);
    localparam int PA_W  = DATA_W + 1;
    localparam int P_W   = PA_W + COEF_W;

    // tap 0 is the live input; the registers hold taps 1..NTAPS-1
    logic signed [DATA_W-1:0] r_dl   [NTAPS-1];
    logic signed [DATA_W-1:0] w_win  [NTAPS];
    logic signed [COEF_W-1:0] r_coef [NCOEF];
    // coefficient snapshot taken at acceptance so a same-cycle write misses this sample
    logic signed [COEF_W-1:0] r_c1   [NCOEF];
    logic signed [PA_W-1:0]   w_pa   [NCOEF];
    logic signed [PA_W-1:0]   r_pa   [NCOEF];
    logic signed [P_W-1:0]    r_p    [NCOEF];
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [DATA_W-1:0] r_raw1;
    logic signed [DATA_W-1:0] r_raw2;
    logic                     r_v1;
    logic                     r_v2;
    logic                     r_b1;
    logic                     r_b2;
    logic                     w_stall;
    logic                     w_take;
    logic [DATA_W-1:0]        w_rs;
    logic                     w_sat;

    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_take   = in_valid & ~w_stall;

    always_comb begin
        w_win[0] = in_data;
        for (int k = 1; k < NTAPS; k++) w_win[k] = r_dl[k-1];
    end

    always_comb begin
        w_pa = '{default: '0};
        for (int k = 0; k < NCOEF - 1; k++) w_pa[k] = PA_W'(w_win[k]) + PA_W'(w_win[NTAPS-1-k]);
        w_pa[NCOEF-1] = PA_W'(w_win[NCOEF-1]);
    end

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NCOEF; k++) w_acc = w_acc + ACC_W'(r_p[k]);
    end

    fir_round_sat #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .i_acc (w_acc),
        .o_data(w_rs),
        .o_sat (w_sat)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dl      <= '{default: '0};
            r_coef    <= '{default: '0};
            r_c1      <= '{default: '0};
            r_pa      <= '{default: '0};
            r_p       <= '{default: '0};
            r_raw1    <= '0;
            r_raw2    <= '0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_b1      <= 1'b0;
            r_b2      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (coef_we && ({1'b0, coef_addr} < (AW+1)'(NCOEF))) r_coef[coef_addr] <= coef_wdata;
            if (!w_stall) begin
                r_v1      <= w_take;
                r_v2      <= r_v1;
                out_valid <= r_v2;
                if (w_take) begin
                    for (int k = 0; k < NTAPS - 1; k++) r_dl[k] <= w_win[k];
                    r_pa   <= w_pa;
                    r_c1   <= r_coef;
                    r_b1   <= bypass;
                    r_raw1 <= w_win[NCOEF-1];
                end
                if (r_v1) begin
                    for (int k = 0; k < NCOEF; k++) r_p[k] <= P_W'(r_pa[k]) * P_W'(r_c1[k]);
                    r_b2   <= r_b1;
                    r_raw2 <= r_raw1;
                end
                if (r_v2) begin
                    out_data <= r_b2 ? r_raw2 : w_rs;
                    out_sat  <= ~r_b2 & w_sat;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_sym_pipe.sv
// tb_fir_sym_pipe: directed checks of fir_sym_pipe against a direct-form reference
module tb_fir_sym_pipe;
    logic       clk = 0;
    logic       n_rst = 0;
    logic       in_valid = 0;
    logic [7:0] in_data = 0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sat;
    logic       out_ready = 1;
    logic       bypass = 0;
    logic       coef_we = 0;
    logic [3:0] coef_addr = 0;
    logic [7:0] coef_wdata = 0;

    fir_sym_pipe dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_ready (out_ready),
        .bypass    (bypass),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    int         h [10];
    int         hist [19];
    logic [8:0] exp_q [$];
    int         log_d [1024];
    int         log_s [1024];
    int         n_out = 0;
    int         base;
    int         held;
    int         bpc [10] = '{3, -5, 7, -9, 11, -13, 20, -30, 60, 100};

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!n_rst) begin
            exp_q.delete();
            foreach (hist[k]) hist[k] = 0;
            foreach (h[k]) h[k] = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", 1, 0);
                else check("out", int'({out_sat, out_data}), int'(exp_q.pop_front()));
                if (n_out < 1024) begin
                    log_d[n_out] = int'($signed(out_data));
                    log_s[n_out] = int'(out_sat);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                int acc;
                int r;
                logic [8:0] e;
                for (int k = 18; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'($signed(in_data));
                acc = 0;
                for (int k = 0; k < 19; k++) acc += h[k < 10 ? k : 18 - k] * hist[k];
                r = (acc + 512) >>> 10;
                if (bypass) e = {1'b0, 8'(hist[9])};
                else if (r > 127) e = {1'b1, 8'h7f};
                else if (r < -128) e = {1'b1, 8'h80};
                else e = {1'b0, 8'(r)};
                exp_q.push_back(e);
            end
            if (coef_we && coef_addr < 10) h[coef_addr] = int'($signed(coef_wdata));
        end
    end

    task automatic send(input int d, input bit byp);
        int t;
        t = 0;
        in_valid = 1;
        in_data  = d[7:0];
        bypass   = byp;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wcoef(input int a, input int v);
        coef_we    = 1;
        coef_addr  = a[3:0];
        coef_wdata = v[7:0];
        @(posedge clk);
        #1;
        coef_we = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_sat", int'(out_sat), 0);
        @(posedge clk);
        #1 n_rst = 1;
        @(negedge clk);
        check("rel_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        wcoef(9, 127);
        base = n_out;
        for (int i = 0; i < 20; i++) send(i == 0 ? 127 : 0, 0);
        drain();
        check("imp_count", n_out - base, 20);
        for (int j = 0; j < 20; j++) check($sformatf("imp[%0d]", j), log_d[base+j], j == 9 ? 16 : 0);

        for (int a = 0; a < 10; a++) wcoef(a, 127);
        base = n_out;
        for (int i = 0; i < 19; i++) send(127, 0);
        drain();
        check("sat_hi_data", log_d[base+18], 127);
        check("sat_hi_flag", log_s[base+18], 1);
        base = n_out;
        for (int i = 0; i < 19; i++) send(-128, 0);
        drain();
        check("sat_lo_data", log_d[base+18], -128);
        check("sat_lo_flag", log_s[base+18], 1);

        for (int a = 0; a < 10; a++) wcoef(a, bpc[a]);
        base = n_out;
        fork
            for (int i = 0; i < 30; i++) send((i * 37) % 256 - 128, 0);
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 0;
                @(negedge clk);
                held = int'(out_data);
                check("stall_in_ready", int'(in_ready), 0);
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", int'(in_ready), 0);
                    check("stall_hold", int'(out_data), held);
                end
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        check("bp_count", n_out - base, 30);

        for (int a = 0; a < 9; a++) wcoef(a, 0);
        wcoef(9, 127);
        base = n_out;
        for (int i = 0; i < 40; i++) begin
            if (i == 9) begin
                coef_we = 1; coef_addr = 9; coef_wdata = 64;
            end
            if (i == 12) begin
                coef_we = 1; coef_addr = 10; coef_wdata = 99;
            end
            send((i == 0 || i == 1 || i == 20) ? 127 : 0, 0);
            coef_we = 0;
        end
        drain();
        check("coef_old", log_d[base+9], 16);
        check("coef_new", log_d[base+10], 8);
        check("coef_zero", log_d[base+11], 0);
        check("coef_addr10", log_d[base+29], 8);

        base = n_out;
        for (int i = 0; i < 12; i++) send(i < 3 ? i + 1 : 0, 1);
        drain();
        check("byp_pre", log_d[base], 0);
        check("byp_1", log_d[base+9], 1);
        check("byp_2", log_d[base+10], 2);
        check("byp_3", log_d[base+11], 3);
        check("byp_sat", log_s[base+9], 0);

        send(5, 0);
        send(6, 0);
        send(7, 0);
        n_rst = 0;
        @(negedge clk);
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_data", int'(out_data), 0);
        base = n_out;
        repeat (2) @(posedge clk);
        #1 n_rst = 1;
        repeat (12) @(negedge clk);
        check("rst_residual", n_out - base, 0);
        check("rst_rel_ready", int'(in_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fir_sym_pipe.md
FIR_SYM_PIPE -- requirements
Module: fir_sym_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, signed sample width of input and output.
REQ-002 The block SHALL have parameter COEF_W, default 8, signed coefficient width.
REQ-003 The block SHALL have parameter NTAPS, default 19, tap count; odd values only, minimum 3.
REQ-004 The block SHALL have parameter SHIFT, default 10, right shift applied to the accumulator before output.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 The block SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1, a sample is offered on in_data.
REQ-008 The block SHALL have port in_data, input, DATA_W, signed input sample.
REQ-009 The block SHALL have port in_ready, output, 1, the block accepts in_data this cycle.
REQ-010 The block SHALL have port out_valid, output, 1, out_data and out_sat hold a result.
REQ-011 The block SHALL have port out_data, output, DATA_W, signed filtered sample.
REQ-012 The block SHALL have port out_sat, output, 1, out_data was clipped.
REQ-013 The block SHALL have port out_ready, input, 1, the downstream consumer takes the result.
REQ-014 The block SHALL have port bypass, input, 1, pass the delayed raw sample instead of the filter result.
REQ-015 The block SHALL have ports coef_we (input, 1), coef_addr (input, clog2(NCOEF)) and coef_wdata (input, COEF_W), the coefficient write port; NCOEF = (NTAPS+1)/2.

Function
REQ-016 An input sample SHALL be accepted when in_valid and in_ready are both high; only accepted samples shift the NTAPS-deep delay line.
REQ-017 Stall = out_valid and not out_ready; in_ready SHALL equal not stall, and all pipeline registers SHALL hold their values during stall.
REQ-018 The result for an accepted sample x[n] SHALL be y[n] = sum over k=0..NTAPS-1 of h[k]*x[n-k], with h[k] = h[NTAPS-1-k] and only h[0..NCOEF-1] stored.
REQ-019 The datapath SHALL be stage 1 pre-add (DATA_W+1 bits), stage 2 NCOEF products, stage 3 sum, round and saturate; out_valid SHALL rise exactly 3 unstalled cycles after acceptance.
REQ-020 The accumulator SHALL be ACC_W = DATA_W+1+COEF_W+clog2(NCOEF) bits signed, with no internal overflow possible.
REQ-021 Rounding SHALL be round-half-up: (acc + 2^(SHIFT-1)) >>> SHIFT; for SHIFT=0 the accumulator SHALL be used unchanged.
REQ-022 The rounded value SHALL be saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], with out_sat=1 exactly when clipping occurred.
REQ-023 When bypass=1 at acceptance, out_data SHALL equal the sample at delay line tap NCOEF-1 (group delay) with out_sat=0, at the same 3-cycle latency; bypass SHALL be sampled per sample.
REQ-024 A coefficient write SHALL take effect for samples accepted in the cycle after coef_we; writes with coef_addr >= NCOEF SHALL be ignored.
REQ-025 A write coinciding with acceptance SHALL NOT affect that sample's products.
REQ-026 A bubble (no acceptance) SHALL propagate as out_valid=0 and SHALL NOT alter out_data.

Reset
REQ-027 While n_rst=0, the delay line, pipeline registers, coefficients, out_data and out_sat SHALL be 0, and out_valid SHALL be 0; in_ready SHALL be 1 after release.
REQ-028 Reset mid-stream SHALL discard all in-flight results with no output pulse after release.

Structure
REQ-029 Package fir_pkg SHALL hold the clog2 function and the NCOEF and ACC_W derivation functions.
REQ-030 Rounding and saturation SHALL be a sub-module fir_round_sat (params ACC_W, DATA_W, SHIFT).
REQ-031 Coefficients SHALL be flop registers, not memory.

Verification
REQ-032 Impulse test: h[9]=127, all other coefficients 0; input 127 then zeros -> one output of 16 (16129/1024 rounded) at sample index 9, all others 0.
REQ-033 Saturation test: all coefficients 127, constant input 127 -> steady output 127 with out_sat=1; constant input -128 -> output -128 with out_sat=1.
REQ-034 Backpressure test: out_ready held low 5 cycles with a stream running -> in_ready=0, out_data held, no sample lost or duplicated versus the golden model.
REQ-035 Coefficient test: rewrite h[9] from 127 to 64 mid-stream -> products change for samples accepted from the next cycle on; a write to coef_addr=10 has no effect.
REQ-036 Bypass and reset test: bypass=1 with input ramp 1,2,3 -> outputs equal the ramp delayed by 9 samples; asserting n_rst with 3 results in flight -> out_valid=0 and no residual outputs.
